// File: rtl/vec_fp16_seq_alu.sv
// Multi-cycle vector FP16 execution unit: lane-serial add/scalar-multiply, accumulating
// dot product and single-beat integer ops behind a start/busy/done handshake.
module vec_fp16_seq_alu #(
   parameter int unsigned LANES           = 16,
   parameter int unsigned LANES_PER_CYCLE = 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic [3:0]            opcode,
   input  logic [16*LANES-1:0]   op_1,
   input  logic [16*LANES-1:0]   op_2,
   output logic                  busy,
   output logic                  done,
   output logic [16*LANES-1:0]   result,
   output logic                  ovf
);

   localparam int unsigned W   = 16 * LANES;
   localparam int unsigned CW  = $clog2(LANES) + 1;
   localparam int unsigned LPC = LANES_PER_CYCLE;

   localparam logic [3:0] OP_VADD = 4'b0000;
   localparam logic [3:0] OP_VDOT = 4'b0001;
   localparam logic [3:0] OP_SMUL = 4'b0010;
   localparam logic [3:0] OP_SST  = 4'b0011;
   localparam logic [3:0] OP_VLD  = 4'b0100;
   localparam logic [3:0] OP_VST  = 4'b0101;
   localparam logic [3:0] OP_SLL  = 4'b0110;
   localparam logic [3:0] OP_SLH  = 4'b0111;
   localparam logic [3:0] OP_J    = 4'b1000;

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   // IEEE half add: denormal inputs, guard/round/sticky alignment, round-to-nearest-even
   function automatic logic [15:0] fp16_add(input logic [15:0] x, input logic [15:0] y);
      logic        sa, sb;
      logic [4:0]  ea, eb, d;
      logic [10:0] ma, mb, mant;
      logic [47:0] bw;
      logic [13:0] a14, b14;
      logic [14:0] v;
      logic [11:0] mr;
      logic [6:0]  e_r;
      logic        rnd;
      logic [15:0] r;
      r = 16'h0000;
      if (x[14:10] == 5'h1f) begin
         r = {x[15], 5'h1f, 10'h000};
      end else if (y[14:10] == 5'h1f) begin
         r = {y[15], 5'h1f, 10'h000};
      end else begin
         // larger magnitude becomes operand a; raw bit order is monotonic in magnitude
         if (x[14:0] >= y[14:0]) begin
            sa = x[15]; ea = (x[14:10] == 5'd0) ? 5'd1 : x[14:10]; ma = {x[14:10] != 5'd0, x[9:0]};
            sb = y[15]; eb = (y[14:10] == 5'd0) ? 5'd1 : y[14:10]; mb = {y[14:10] != 5'd0, y[9:0]};
         end else begin
            sa = y[15]; ea = (y[14:10] == 5'd0) ? 5'd1 : y[14:10]; ma = {y[14:10] != 5'd0, y[9:0]};
            sb = x[15]; eb = (x[14:10] == 5'd0) ? 5'd1 : x[14:10]; mb = {x[14:10] != 5'd0, x[9:0]};
         end
         d   = ea - eb;
         bw  = {mb, 37'd0} >> d;
         b14 = {bw[47:35], bw[34] | (|bw[33:0])};
         a14 = {ma, 3'b000};
         if (sa == sb) v = {1'b0, a14} + {1'b0, b14};
         else          v = {1'b0, a14} - {1'b0, b14};
         if (v != 15'd0) begin
            e_r = {2'b00, ea};
            if (v[14]) begin
               v   = {1'b0, v[14:2], v[1] | v[0]};
               e_r = e_r + 7'd1;
            end else begin
               for (int i = 0; i < 13; i++) begin
                  if (!v[13] && (e_r > 7'd1)) begin
                     v   = {v[13:0], 1'b0};
                     e_r = e_r - 7'd1;
                  end
               end
            end
            mant = v[13:3];
            rnd  = v[2] & (v[1] | v[0] | v[3]);
            mr   = {1'b0, mant} + 12'(rnd);
            if (mr[11]) begin
               mant = mr[11:1];
               e_r  = e_r + 7'd1;
            end else begin
               mant = mr[10:0];
            end
            if (e_r >= 7'd31) r = {sa, 5'h1f, 10'h000};
            else              r = {sa, mant[10] ? e_r[4:0] : 5'd0, mant[9:0]};
         end
      end
      return r;
   endfunction

   // Half multiply: denormals flush to zero, mantissa truncated
   function automatic logic [15:0] fp16_mul(input logic [15:0] x, input logic [15:0] y);
      logic        s;
      logic [21:0] p;
      logic [9:0]  mant;
      int          ue;
      logic [15:0] r;
      s = x[15] ^ y[15];
      if ((x[14:10] == 5'd0) || (y[14:10] == 5'd0)) begin
         r = 16'h0000;
      end else begin
         p  = {11'd0, 1'b1, x[9:0]} * {11'd0, 1'b1, y[9:0]};
         ue = int'(x[14:10]) + int'(y[14:10]) - 30;
         if (p[21]) begin
            mant = p[20:11];
            ue   = ue + 1;
         end else begin
            mant = p[19:10];
         end
         if (ue > 15)       r = {s, 5'h1f, 10'h000};
         else if (ue < -14) r = {s, 15'd0};
         else               r = {s, 5'(ue + 15), mant};
      end
      return r;
   endfunction

   state_t          state_q, state_d;
   logic            busy_q, busy_d, done_q, done_d, ovf_q, ovf_d;
   logic [3:0]      opcode_q, opcode_d;
   logic [W-1:0]    a_q, a_d, b_q, b_d, result_q, result_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [15:0]     acc_q, acc_d;
   logic [15:0]     lane_r, prod;
   logic            last;

   always_comb begin
      state_d  = state_q;
      busy_d   = busy_q;
      done_d   = 1'b0;
      ovf_d    = ovf_q;
      opcode_d = opcode_q;
      a_d      = a_q;
      b_d      = b_q;
      result_d = result_q;
      cnt_d    = cnt_q;
      acc_d    = acc_q;
      lane_r   = 16'h0000;
      prod     = 16'h0000;
      last     = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               opcode_d = opcode;
               a_d      = op_1;
               b_d      = op_2;
               result_d = '0;
               ovf_d    = 1'b0;
               acc_d    = 16'h0000;
               cnt_d    = '0;
               busy_d   = 1'b1;
               state_d  = S_RUN;
            end
         end
         S_RUN: begin
            case (opcode_q)
               OP_VADD, OP_SMUL: begin
                  for (int j = 0; j < int'(LPC); j++) begin
                     if (opcode_q == OP_VADD)
                        lane_r = fp16_add(a_q[16*(int'(cnt_q)+j) +: 16], b_q[16*(int'(cnt_q)+j) +: 16]);
                     else
                        lane_r = fp16_mul(a_q[16*(int'(cnt_q)+j) +: 16], b_q[15:0]);
                     result_d[16*(int'(cnt_q)+j) +: 16] = lane_r;
                     if (lane_r[14:10] == 5'h1f) ovf_d = 1'b1;
                  end
                  cnt_d = cnt_q + CW'(LPC);
                  last  = (cnt_d == CW'(LANES));
               end
               OP_VDOT: begin
                  // the running sum is mirrored into lane 0 every beat; other lanes stay cleared
                  prod           = fp16_mul(a_q[16*int'(cnt_q) +: 16], b_q[16*int'(cnt_q) +: 16]);
                  lane_r         = fp16_add(acc_q, prod);
                  acc_d          = lane_r;
                  result_d[15:0] = lane_r;
                  if ((prod[14:10] == 5'h1f) || (lane_r[14:10] == 5'h1f)) ovf_d = 1'b1;
                  cnt_d = cnt_q + CW'(1);
                  last  = (cnt_d == CW'(LANES));
               end
               OP_SST, OP_VLD, OP_VST, OP_J: begin
                  result_d = a_q + b_q;
                  last     = 1'b1;
               end
               OP_SLL: begin
                  result_d = W'({a_q[15:8], b_q[7:0]});
                  last     = 1'b1;
               end
               OP_SLH: begin
                  result_d = W'({b_q[7:0], a_q[7:0]});
                  last     = 1'b1;
               end
               default: begin
                  result_d = '0;
                  last     = 1'b1;
               end
            endcase
            if (last) begin
               busy_d  = 1'b0;
               done_d  = 1'b1;
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         ovf_q    <= 1'b0;
         opcode_q <= 4'd0;
         a_q      <= '0;
         b_q      <= '0;
         result_q <= '0;
         cnt_q    <= '0;
         acc_q    <= 16'h0000;
      end else begin
         state_q  <= state_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         ovf_q    <= ovf_d;
         opcode_q <= opcode_d;
         a_q      <= a_d;
         b_q      <= b_d;
         result_q <= result_d;
         cnt_q    <= cnt_d;
         acc_q    <= acc_d;
      end
   end

   assign busy   = busy_q;
   assign done   = done_q;
   assign result = result_q;
   assign ovf    = ovf_q;

endmodule

// File: tb/tb_vec_fp16_seq_alu.sv
// Bench for vec_fp16_seq_alu: vector table with a result scoreboard, plus hand sequences
// for ignored starts and mid-operation reset. Instances with 1 and 4 lanes per beat.
module tb_vec_fp16_seq_alu;

   localparam int unsigned LANES = 16;
   localparam int unsigned W     = 16 * LANES;

   logic          clk = 1'b0;
   logic          rst_n, start1, start4;
   logic [3:0]    opcode;
   logic [W-1:0]  op_1, op_2;
   logic          busy1, done1, ovf1, busy4, done4, ovf4;
   logic [W-1:0]  res1, res4;

   int n_chk = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   vec_fp16_seq_alu #(.LANES(LANES), .LANES_PER_CYCLE(1)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .start(start1), .opcode(opcode), .op_1(op_1), .op_2(op_2),
      .busy(busy1), .done(done1), .result(res1), .ovf(ovf1));

   vec_fp16_seq_alu #(.LANES(LANES), .LANES_PER_CYCLE(4)) u_dut4 (
      .clk(clk), .rst_n(rst_n), .start(start4), .opcode(opcode), .op_1(op_1), .op_2(op_2),
      .busy(busy4), .done(done4), .result(res4), .ovf(ovf4));

   typedef struct {
      logic [W-1:0] res;
      logic         ovf;
      int           lat;
   } exp_t;

   typedef struct {
      string        name;
      logic         sel;
      logic [3:0]   op;
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W-1:0] res;
      logic         ovf;
      int           lat;
   } vec_t;

   exp_t sb[$];
   vec_t vt[$];

   task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp_v);
      n_chk++;
      if (act !== exp_v) begin
         n_bad++;
         $display("FAIL %s: got %h want %h", nm, act, exp_v);
      end
   endtask

   function automatic vec_t mk(input string n, input logic s, input logic [3:0] op,
                               input logic [W-1:0] a, input logic [W-1:0] b,
                               input logic [W-1:0] r, input logic o, input int l);
      vec_t v;
      v.name = n; v.sel = s; v.op = op; v.a = a; v.b = b; v.res = r; v.ovf = o; v.lat = l;
      return v;
   endfunction

   // Drive one op, push its expectation, wait for done, pop and compare
   task automatic run_op(input vec_t v);
      exp_t e;
      int   n;
      @(negedge clk);
      opcode = v.op; op_1 = v.a; op_2 = v.b;
      start1 = !v.sel; start4 = v.sel;
      e.res = v.res; e.ovf = v.ovf; e.lat = v.lat;
      sb.push_back(e);
      @(negedge clk);
      start1 = 1'b0; start4 = 1'b0;
      opcode = ~v.op; op_1 = ~v.a; op_2 = ~v.b;
      n = 1;
      chk({v.name, " busy_after_accept"}, W'(v.sel ? busy4 : busy1), W'(1));
      while (!(v.sel ? done4 : done1) && n < 200) begin
         @(negedge clk);
         n++;
      end
      e = sb.pop_front();
      chk({v.name, " latency"}, W'(n), W'(e.lat));
      chk({v.name, " result"}, v.sel ? res4 : res1, e.res);
      chk({v.name, " ovf"}, W'(v.sel ? ovf4 : ovf1), W'(e.ovf));
      chk({v.name, " busy_at_done"}, W'(v.sel ? busy4 : busy1), W'(0));
      @(negedge clk);
      chk({v.name, " done_pulse"}, W'(v.sel ? done4 : done1), W'(0));
      chk({v.name, " result_held"}, v.sel ? res4 : res1, e.res);
   endtask

   initial begin
      logic [W-1:0] a, b, r;
      logic [W-1:0] ones;
      logic [W-1:0] three;
      int           n;
      logic         seen;

      rst_n = 1'b0; start1 = 1'b0; start4 = 1'b0;
      opcode = 4'd0; op_1 = '0; op_2 = '0;
      repeat (3) @(negedge clk);
      chk("reset busy", W'(busy1), W'(0));
      chk("reset done", W'(done1), W'(0));
      chk("reset result", res1, '0);
      chk("reset ovf", W'(ovf1), W'(0));
      chk("reset result lpc4", res4, '0);
      rst_n = 1'b1;

      ones  = {LANES{16'h3C00}};
      three = {LANES{16'h4200}};

      vt.push_back(mk("vadd_lpc1", 1'b0, 4'b0000, ones, {LANES{16'h4000}}, three, 1'b0, 17));
      vt.push_back(mk("vadd_lpc4", 1'b1, 4'b0000, ones, {LANES{16'h4000}}, three, 1'b0, 5));
      vt.push_back(mk("vdot_ones", 1'b0, 4'b0001, ones, ones, W'(16'h4C00), 1'b0, 17));

      b = '0;
      for (int i = 0; i < int'(LANES); i++) b[16*i +: 16] = (i % 2 == 0) ? 16'h4000 : 16'hC000;
      vt.push_back(mk("vdot_cancel", 1'b0, 4'b0001, ones, b, '0, 1'b0, 17));
      vt.push_back(mk("vdot_ovf", 1'b0, 4'b0001, {LANES{16'h7800}}, ones, W'(16'h7C00), 1'b1, 17));

      a = {LANES{16'h3E00}}; r = three;
      a[16*3 +: 16] = 16'h0000; r[16*3 +: 16] = 16'h0000;
      a[16*4 +: 16] = 16'hBE00; r[16*4 +: 16] = 16'hC200;
      a[16*5 +: 16] = 16'h0001; r[16*5 +: 16] = 16'h0000;
      a[16*6 +: 16] = 16'h8000; r[16*6 +: 16] = 16'h0000;
      vt.push_back(mk("smul_lpc1", 1'b0, 4'b0010, a, W'(16'h4000), r, 1'b0, 17));
      vt.push_back(mk("smul_lpc4", 1'b1, 4'b0010, a, W'(16'h4000), r, 1'b0, 5));

      a = {LANES{16'h3E01}}; r = {LANES{16'h4081}};
      a[16*1 +: 16] = 16'h0400; r[16*1 +: 16] = 16'h0601;
      vt.push_back(mk("smul_trunc", 1'b0, 4'b0010, a, W'(16'h3E01), r, 1'b0, 17));

      a = ones; r = {LANES{16'h3800}};
      a[16*0 +: 16] = 16'h0400; r[16*0 +: 16] = 16'h0000;
      a[16*1 +: 16] = 16'h8400; r[16*1 +: 16] = 16'h8000;
      a[16*2 +: 16] = 16'h0800; r[16*2 +: 16] = 16'h0400;
      vt.push_back(mk("smul_underflow", 1'b0, 4'b0010, a, W'(16'h3800), r, 1'b0, 17));
      vt.push_back(mk("smul_ovf", 1'b0, 4'b0010, {LANES{16'h7800}}, W'(16'h4000),
                      {LANES{16'h7C00}}, 1'b1, 17));

      a = '0; b = '0; r = '0;
      a[16*0 +: 16] = 16'h3C00; b[16*0 +: 16] = 16'h1000; r[16*0 +: 16] = 16'h3C00;
      a[16*1 +: 16] = 16'h3C01; b[16*1 +: 16] = 16'h1000; r[16*1 +: 16] = 16'h3C02;
      a[16*2 +: 16] = 16'h0001; b[16*2 +: 16] = 16'h0001; r[16*2 +: 16] = 16'h0002;
      a[16*3 +: 16] = 16'h4200; b[16*3 +: 16] = 16'hC000; r[16*3 +: 16] = 16'h3C00;
      a[16*4 +: 16] = 16'h3C00; b[16*4 +: 16] = 16'hBC00; r[16*4 +: 16] = 16'h0000;
      a[16*5 +: 16] = 16'h03FF; b[16*5 +: 16] = 16'h0001; r[16*5 +: 16] = 16'h0400;
      a[16*6 +: 16] = 16'h7BFF; b[16*6 +: 16] = 16'h3C00; r[16*6 +: 16] = 16'h7BFF;
      a[16*7 +: 16] = 16'h3C00; b[16*7 +: 16] = 16'h0001; r[16*7 +: 16] = 16'h3C00;
      vt.push_back(mk("vadd_round", 1'b0, 4'b0000, a, b, r, 1'b0, 17));

      a = '0; b = '0; r = '0;
      a[16*5 +: 16] = 16'h7BFF; b[16*5 +: 16] = 16'h7BFF; r[16*5 +: 16] = 16'h7C00;
      vt.push_back(mk("vadd_ovf", 1'b0, 4'b0000, a, b, r, 1'b1, 17));
      vt.push_back(mk("vadd_ovf_clear", 1'b0, 4'b0000, ones, {LANES{16'h4000}}, three, 1'b0, 17));

      vt.push_back(mk("sll", 1'b0, 4'b0110, {LANES{16'h1234}}, {LANES{16'hFFAB}},
                      W'(16'h12AB), 1'b0, 2));
      vt.push_back(mk("slh", 1'b0, 4'b0111, {LANES{16'h1234}}, {LANES{16'hFFAB}},
                      W'(16'hAB34), 1'b0, 2));
      vt.push_back(mk("j_wrap", 1'b0, 4'b1000, {W{1'b1}}, W'(1), '0, 1'b0, 2));
      vt.push_back(mk("vld_carry", 1'b0, 4'b0100, W'(16'hFFFF), W'(1), W'(32'h0001_0000), 1'b0, 2));
      vt.push_back(mk("nop_1111", 1'b0, 4'b1111, ones, ones, '0, 1'b0, 2));

      foreach (vt[k]) run_op(vt[k]);

      // start pulses while busy and while done must be ignored
      @(negedge clk);
      opcode = 4'b0000; op_1 = ones; op_2 = {LANES{16'h4000}}; start1 = 1'b1;
      @(negedge clk);
      start1 = 1'b0; n = 1;
      repeat (5) begin @(negedge clk); n++; end
      opcode = 4'b1000; op_1 = {W{1'b1}}; op_2 = W'(1); start1 = 1'b1;
      @(negedge clk);
      start1 = 1'b0; n++;
      while (!done1 && n < 200) begin @(negedge clk); n++; end
      chk("ignore_busy latency", W'(n), W'(17));
      chk("ignore_busy result", res1, three);
      start1 = 1'b1;
      @(negedge clk);
      start1 = 1'b0;
      chk("ignore_done busy", W'(busy1), W'(0));
      chk("ignore_done result", res1, three);
      @(negedge clk);
      chk("ignore_done idle", W'(busy1), W'(0));
      chk("ignore_done result_held", res1, three);

      // reset on beat 8 of an overflowing VADD abandons it with no done
      a = '0; b = '0;
      a[16*5 +: 16] = 16'h7BFF; b[16*5 +: 16] = 16'h7BFF;
      @(negedge clk);
      opcode = 4'b0000; op_1 = a; op_2 = b; start1 = 1'b1;
      @(negedge clk);
      start1 = 1'b0;
      repeat (7) @(negedge clk);
      chk("pre_reset ovf", W'(ovf1), W'(1));
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      chk("mid_reset busy", W'(busy1), W'(0));
      chk("mid_reset done", W'(done1), W'(0));
      chk("mid_reset result", res1, '0);
      chk("mid_reset ovf", W'(ovf1), W'(0));
      seen = 1'b0;
      repeat (30) begin
         @(negedge clk);
         if (done1 || busy1) seen = 1'b1;
      end
      chk("mid_reset no_done", W'(seen), W'(0));
      run_op(mk("after_reset_vadd", 1'b0, 4'b0000, ones, {LANES{16'h4000}}, three, 1'b0, 17));

      $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_bad);
      $finish;
   end

endmodule
